// File: rtl/k423_wb_arb_stage.sv
// Multi-channel write-back stage: per-channel 1-entry buffers granted round-robin onto one RF write port.
// Optional retire counter built only when K423_WB_INSTRET_EN is defined; otherwise wb_instret_o is 0.
`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif
`ifndef CORE_ADDR_W
`define CORE_ADDR_W 32
`endif
`ifndef INST_RSDIDX_W
`define INST_RSDIDX_W 5
`endif

module k423_wb_arb_stage #(
   parameter  int NUM_CH = 3,
   parameter  int XLEN   = `CORE_XLEN,
   parameter  int ADDR_W = `CORE_ADDR_W,
   parameter  int RIDX_W = `INST_RSDIDX_W,
   parameter  int CNT_W  = 64,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [NUM_CH-1:0]        ch_vld_i,
   output logic [NUM_CH-1:0]        ch_rdy_o,
   input  logic [NUM_CH*ADDR_W-1:0] ch_pc_i,
   input  logic [NUM_CH-1:0]        ch_rd_vld_i,
   input  logic [NUM_CH*RIDX_W-1:0] ch_rd_idx_i,
   input  logic [NUM_CH*XLEN-1:0]   ch_rd_i,
   input  logic                     rf_rdy_i,
   output logic                     wb_vld_o,
   output logic [CH_W-1:0]          wb_ch_o,
   output logic [ADDR_W-1:0]        wb_pc_o,
   output logic                     wb_rd_vld_o,
   output logic [RIDX_W-1:0]        wb_rd_idx_o,
   output logic [XLEN-1:0]          wb_rd_o,
   output logic [CNT_W-1:0]         wb_instret_o
);
   logic [NUM_CH-1:0]             buf_vld;
   logic [NUM_CH-1:0]             buf_rd_vld;
   logic [NUM_CH-1:0][ADDR_W-1:0] buf_pc;
   logic [NUM_CH-1:0][RIDX_W-1:0] buf_rd_idx;
   logic [NUM_CH-1:0][XLEN-1:0]   buf_rd;
   logic [CH_W-1:0]               ptr;
   logic [CH_W-1:0]               sel;
   logic                          found;
   logic                          take;
   logic [NUM_CH-1:0]             grant;
   int                            c;

   // Rotating search starting at ptr; first occupied buffer wins.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      c     = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         c = int'(ptr) + k;
         if (c >= NUM_CH) c = c - NUM_CH;
         if (!found && buf_vld[c]) begin
            found = 1'b1;
            sel   = CH_W'(c);
         end
      end
   end

   assign take = found & rf_rdy_i;

   always_comb begin
      grant = '0;
      if (take) grant[sel] = 1'b1;
   end

   // A granted buffer frees its slot in the same cycle, so a full channel can stream.
   assign ch_rdy_o = ~buf_vld | grant;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         buf_vld <= '0;
         ptr     <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_vld_i[i] && ch_rdy_o[i]) buf_vld[i] <= 1'b1;
            else if (grant[i])              buf_vld[i] <= 1'b0;
         end
         if (take) ptr <= (sel == CH_W'(NUM_CH-1)) ? '0 : sel + CH_W'(1);
      end
   end

   // Payload needs no reset: it is only observed through a grant.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_vld_i[i] && ch_rdy_o[i]) begin
            buf_pc[i]     <= ch_pc_i[i*ADDR_W +: ADDR_W];
            buf_rd_vld[i] <= ch_rd_vld_i[i];
            buf_rd_idx[i] <= ch_rd_idx_i[i*RIDX_W +: RIDX_W];
            buf_rd[i]     <= ch_rd_i[i*XLEN +: XLEN];
         end
      end
   end

   assign wb_vld_o    = take;
   assign wb_ch_o     = take ? sel : '0;
   assign wb_pc_o     = take ? buf_pc[sel] : '0;
   assign wb_rd_idx_o = take ? buf_rd_idx[sel] : '0;
   assign wb_rd_o     = take ? buf_rd[sel] : '0;
   assign wb_rd_vld_o = take & buf_rd_vld[sel] & (buf_rd_idx[sel] != '0);

`ifdef K423_WB_INSTRET_EN
   logic [CNT_W-1:0] instret;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i)  instret <= '0;
      else if (take) instret <= instret + CNT_W'(1);
   end

   assign wb_instret_o = instret;
`else
   assign wb_instret_o = '0;
`endif

endmodule
